// File: rtl/mips_mul_pkg.sv
// Shared definitions for the MIPS32 iterative multiplier and its decoder.
package mips_mul_pkg;

    // Default operand and destination-tag widths
    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAGW  = 5;

    // SPECIAL-opcode funct codes for the signed and unsigned multiply
    localparam logic [5:0] FUNCT_MUL  = 6'h18;
    localparam logic [5:0] FUNCT_MULU = 6'h19;

    // Multiplier control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage : mips_mul_pkg

// File: rtl/mips_mul_unit.sv
// Radix-2 shift-add multiplier for the EX stage: one operand pair at a time,
// fixed WIDTH-cycle latency, full 2*WIDTH-bit product returned with its tag.
module mips_mul_unit
    import mips_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAGW  = DEF_TAGW
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic               req_signed,
    input  logic [TAGW-1:0]    req_tag,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_lo,
    output logic [WIDTH-1:0]   resp_hi,
    output logic [TAGW-1:0]    resp_tag
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    mul_state_e         r_state;
    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_req_ready;
    logic               r_resp_valid;
    logic [WIDTH-1:0]   r_resp_lo;
    logic [WIDTH-1:0]   r_resp_hi;
    logic [TAGW-1:0]    r_resp_tag;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_neg;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_upper;
    logic [2*WIDTH:0]   w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_signed;

    // Operand magnitudes and result sign; -2^(WIDTH-1) stays representable unsigned
    always_comb begin
        w_a_mag = req_a;
        w_b_mag = req_b;
        if (req_signed && req_a[WIDTH-1]) begin
            w_a_mag = (~req_a) + ONE_W;
        end else begin
            w_a_mag = req_a;
        end
        if (req_signed && req_b[WIDTH-1]) begin
            w_b_mag = (~req_b) + ONE_W;
        end else begin
            w_b_mag = req_b;
        end
        w_neg = req_signed & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
    end

    // One shift-add step: conditionally add the multiplicand to the upper half, then shift
    always_comb begin
        w_addend = {1'b0, r_mcand} & {(WIDTH+1){r_mplier[0]}};
        w_upper  = r_acc[2*WIDTH:WIDTH] + w_addend;
        w_acc_next = {w_upper, r_acc[WIDTH-1:0]} >> 1;
        w_prod = w_acc_next[2*WIDTH-1:0];
        if (r_neg) begin
            w_prod_signed = -w_prod;
        end else begin
            w_prod_signed = w_prod;
        end
    end

    // Control FSM, iteration datapath and registered response
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_cnt        <= '0;
            r_neg        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_lo    <= '0;
            r_resp_hi    <= '0;
            r_resp_tag   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_mcand     <= w_a_mag;
                        r_mplier    <= w_b_mag;
                        r_neg       <= w_neg;
                        r_resp_tag  <= req_tag;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_RUN;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_resp_lo    <= w_prod_signed[WIDTH-1:0];
                        r_resp_hi    <= w_prod_signed[2*WIDTH-1:WIDTH];
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_lo    = r_resp_lo;
    assign resp_hi    = r_resp_hi;
    assign resp_tag   = r_resp_tag;

endmodule : mips_mul_unit

// File: tb/tb_mips_mul_unit.sv
// Directed bench for mips_mul_unit: products, latency, backpressure and mid-run reset.
module tb_mips_mul_unit;

    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk1;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          req_signed;
    logic [TW-1:0] req_tag;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  resp_lo;
    logic [W-1:0]  resp_hi;
    logic [TW-1:0] resp_tag;

    int n_checks = 0;
    int n_errors = 0;

    mips_mul_unit #(.WIDTH(W), .TAGW(TW)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_lo    (resp_lo),
        .resp_hi    (resp_hi),
        .resp_tag   (resp_tag)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present a request just after an edge; it is accepted on the next edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [TW-1:0] t);
        chk("ready_before_issue", {63'd0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_signed = s;
        req_tag    = t;
        @(posedge clk1); #1;
        req_valid  = 1'b0;
        req_a      = 32'hDEAD_BEEF;
        req_b      = 32'h1234_5678;
    endtask

    // Called #1 after the acceptance edge; counts edges until resp_valid rises.
    task automatic wait_resp(input string name, input logic [W-1:0] exp_lo,
                             input logic [W-1:0] exp_hi, input logic [TW-1:0] exp_tag);
        int cycles;
        cycles = 0;
        while (!resp_valid && cycles < 200) begin
            @(posedge clk1); #1;
            cycles++;
        end
        chk({name, "_latency"}, 64'(cycles), 64'd32);
        chk({name, "_lo"}, {32'd0, resp_lo}, {32'd0, exp_lo});
        chk({name, "_hi"}, {32'd0, resp_hi}, {32'd0, exp_hi});
        chk({name, "_tag"}, {59'd0, resp_tag}, {59'd0, exp_tag});
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [TW-1:0] t,
                          input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
        issue(a, b, s, t);
        chk({name, "_busy"}, {63'd0, req_ready}, 64'd0);
        wait_resp(name, exp_lo, exp_hi, t);
        // resp_ready is high, so this edge is the handshake
        @(posedge clk1); #1;
        chk({name, "_valid_fall"}, {63'd0, resp_valid}, 64'd0);
        chk({name, "_ready_rise"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_signed = 1'b0;
        req_tag    = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk1);
        #1 rst = 1'b0;

        chk("rst_req_ready",  {63'd0, req_ready},  64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_lo",    {32'd0, resp_lo},    64'd0);
        chk("rst_resp_hi",    {32'd0, resp_hi},    64'd0);
        chk("rst_resp_tag",   {59'd0, resp_tag},   64'd0);

        run_op("u3x4",     32'd3,          32'd4,          1'b0, 5'd3,  32'd12,         32'd0);
        run_op("s_m3x4",   32'hFFFF_FFFD,  32'd4,          1'b1, 5'd7,  32'hFFFF_FFF4,  32'hFFFF_FFFF);
        run_op("u_ffx2",   32'hFFFF_FFFF,  32'd2,          1'b0, 5'd12, 32'hFFFF_FFFE,  32'h0000_0001);
        run_op("s_ffx2",   32'hFFFF_FFFF,  32'd2,          1'b1, 5'd13, 32'hFFFF_FFFE,  32'hFFFF_FFFF);
        run_op("s_minxm1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 5'd31, 32'h8000_0000,  32'h0000_0000);
        run_op("u_ffxff",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 5'd1,  32'h0000_0001,  32'hFFFF_FFFE);

        // Backpressure: hold resp_ready low with a second request waiting
        resp_ready = 1'b0;
        issue(32'd5, 32'd7, 1'b0, 5'd9);
        wait_resp("bp_first", 32'd35, 32'd0, 5'd9);
        req_valid  = 1'b1;
        req_a      = 32'd2;
        req_b      = 32'd3;
        req_signed = 1'b0;
        req_tag    = 5'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk1); #1;
            chk("bp_hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_hold_ready", {63'd0, req_ready},  64'd0);
            chk("bp_hold_lo",    {32'd0, resp_lo},    64'd35);
            chk("bp_hold_tag",   {59'd0, resp_tag},   64'd9);
        end
        resp_ready = 1'b1;
        @(posedge clk1); #1;
        chk("bp_hs_valid", {63'd0, resp_valid}, 64'd0);
        chk("bp_hs_ready", {63'd0, req_ready},  64'd1);
        @(posedge clk1); #1;
        chk("bp_second_accept", {63'd0, req_ready}, 64'd0);
        req_valid = 1'b0;
        wait_resp("bp_second", 32'd6, 32'd0, 5'd4);
        @(posedge clk1); #1;
        chk("bp_second_done", {63'd0, resp_valid}, 64'd0);

        // Reset sampled on the 10th RUN edge discards the operation
        issue(32'd9, 32'd9, 1'b0, 5'd2);
        repeat (9) begin
            @(posedge clk1); #1;
        end
        rst = 1'b1;
        @(posedge clk1); #1;
        rst = 1'b0;
        chk("mid_rst_ready", {63'd0, req_ready},  64'd1);
        chk("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("mid_rst_lo",    {32'd0, resp_lo},    64'd0);
        chk("mid_rst_tag",   {59'd0, resp_tag},   64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk1); #1;
            if (resp_valid) seen++;
        end
        chk("mid_rst_no_resp", 64'(seen), 64'd0);
        run_op("u7x6", 32'd7, 32'd6, 1'b0, 5'd6, 32'd42, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mips_mul_unit

// File: doc/mips_mul_unit.md
# mips_mul_unit

Iterative multi-cycle integer multiplier serving the EX stage of `pipe_MIPS32`. The EX stage issues MUL/MULU operations as the initiator. This block accepts one operand pair at a time and returns the full 2×WIDTH-bit product with the destination register tag. The pipeline writes `resp_lo` to `rd`. The radix-2 shift-add datapath keeps area small, at the cost of a fixed WIDTH-cycle latency.

## Interface
- `WIDTH`, 32, operand width in bits; must be ≥ 4.
- `TAGW`, 5, width of the destination-register tag.

- `clk1`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  initiator presents an operation.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_a`  in  WIDTH  multiplicand (rs).
- `req_b`  in  WIDTH  multiplier (rt).
- `req_signed`  in  1  1 = MUL (two's complement); 0 = MULU.
- `req_tag`  in  TAGW  destination register index.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  initiator consumes the result.
- `resp_lo`  out  WIDTH  product bits [WIDTH-1:0].
- `resp_hi`  out  WIDTH  product bits [2·WIDTH-1:WIDTH].
- `resp_tag`  out  TAGW  tag captured at acceptance.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`:
    - Capture |a|, |b|, the tag, and `neg` = `req_signed` & (a[MSB] ^ b[MSB]).
    - Clear the accumulator and set `cnt` = 0.
    - Go to RUN.
  - For unsigned operations, magnitude = operand.
  - For signed operations, magnitude = two's-complement negation when MSB = 1. The magnitude is held in WIDTH bits, so −2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned with no overflow.
- **RUN**, one iteration per cycle:
  - If multiplier bit 0 = 1, add the multiplicand to the upper half of the 2·WIDTH+1-bit accumulator.
  - Shift the accumulator and multiplier right by 1.
  - Increment `cnt`.
  - On the iteration where `cnt` = WIDTH−1:
    - Register the product into `resp_hi`/`resp_lo`, negated (2·WIDTH-bit two's complement) if `neg` = 1.
    - Go to DONE.
- **DONE**
  - `resp_valid` = 1; `resp_*` stay stable until the handshake.
  - When `resp_valid` & `resp_ready`, go to IDLE.
- No early termination: latency is data-independent.
- Requests presented while `req_ready` = 0 are ignored; the initiator holds them.
- Reset values:
  - State = IDLE, `req_ready` = 1, `resp_valid` = 0.
  - `resp_lo` = `resp_hi` = 0, `resp_tag` = 0, `cnt` = 0.

## Timing
- Acceptance edge E0 is the edge where `req_valid` & `req_ready`.
- RUN occupies edges E1…E_WIDTH. `resp_valid` rises after E_WIDTH, so latency is WIDTH cycles (32 by default).
- Response edge Er is the edge where `resp_valid` & `resp_ready`:
  - `resp_valid` falls after Er.
  - `req_ready` rises after Er.
  - The next request can be accepted no earlier than edge Er+1.
- Single-operation throughput is one result per WIDTH+2 cycles with `resp_ready` tied high.
- `resp_ready` held low: the unit stays in DONE indefinitely, outputs frozen, and no new request is accepted.
- `rst` during RUN or DONE:
  - The in-flight operation is discarded and no response is issued.
  - Outputs take their reset values on the next edge.
  - `rst` wins over any simultaneous handshake.
- `req_valid` is sampled only in IDLE; operand changes during RUN have no effect.

## Structure
- Shared package `mips_mul_pkg`:
  - State enum (IDLE, RUN, DONE).
  - Default WIDTH/TAGW constants.
  - MUL and MULU funct codes, so the decoder and this unit agree.
- No sub-module is needed. The absolute-value and final-negate logic is small enough to stay inline.
- The counter is $clog2(WIDTH) bits wide.

## Test plan
- Unsigned 3 × 4, tag 3: response after exactly 32 cycles with `resp_lo` = 12, `resp_hi` = 0, `resp_tag` = 3, matching the pipeline's `MUL R3, R1, R2` case.
- Signed −3 × 4 (0xFFFFFFFD, 4): `resp_lo` = 0xFFFFFFF4, `resp_hi` = 0xFFFFFFFF.
- Unsigned 0xFFFFFFFF × 2: `resp_lo` = 0xFFFFFFFE, `resp_hi` = 0x00000001. The same operands with `req_signed` = 1 give `resp_lo` = 0xFFFFFFFE, `resp_hi` = 0xFFFFFFFF.
- Signed 0x80000000 × 0xFFFFFFFF: `resp_lo` = 0x80000000, `resp_hi` = 0x00000000.
- Backpressure:
  - Hold `resp_ready` = 0 for 5 cycles after `resp_valid` rises, and present a second request meanwhile.
  - Required: outputs stable, `req_ready` = 0, and the second request is accepted only on the edge after the response handshake.
- Assert `rst` for one cycle at the 10th RUN cycle:
  - `resp_valid` never rises for that operation.
  - `req_ready` = 1 on the cycle after reset.
  - A fresh 7 × 6 then returns 42.
